// File: rtl/posit_mul_sequencer.sv
// Issue/collect stage in front of posit_mul: queues operand pairs, runs one
// multiply at a time and returns the result with its tag on a valid/ready port.
module posit_mul_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     mul_start,
  output logic [31:0]              mul_a,
  output logic [31:0]              mul_b,
  input  logic                     mul_done,
  input  logic [31:0]              mul_result,
  input  logic                     mul_nar,
  input  logic                     mul_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_nar,
  output logic                     out_zero,
  output logic                     out_timeout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        mem_a   [DEPTH];
  logic [31:0]        mem_b   [DEPTH];
  logic [TAG_W-1:0]   mem_tag [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [15:0]        watchdog;
  logic [TAG_W-1:0]   tag;
  logic               push;
  logic               pop;
  logic               slot_free;
  logic               load_done;
  logic               load_timeout;

  assign in_ready   = (count != CNT_W'(DEPTH));
  assign push       = in_valid & in_ready;
  assign slot_free  = !out_valid | out_ready;
  assign fifo_count = count;
  assign busy       = (state != IDLE) | (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A zero watchdog marks the WAIT entry cycle, where a stale done level is ignored.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    load_done    = 1'b0;
    load_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != '0) && slot_free) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if ((watchdog != 16'd0) && mul_done) begin
          load_done = 1'b1;
          state_nxt = DRAIN;
        end else if (watchdog == 16'(TIMEOUT - 1)) begin
          load_timeout = 1'b1;
          state_nxt    = DRAIN;
        end
      end
      DRAIN: begin
        if (!mul_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Operands and tag are captured on the pop and held until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      tag       <= '0;
      watchdog  <= '0;
    end else begin
      mul_start <= pop;
      if (pop) begin
        mul_a <= mem_a[rd_ptr];
        mul_b <= mem_b[rd_ptr];
        tag   <= mem_tag[rd_ptr];
      end
      if (state == ISSUE) begin
        watchdog <= '0;
      end else if (state == WAIT) begin
        watchdog <= watchdog + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_nar     <= 1'b0;
      out_zero    <= 1'b0;
      out_timeout <= 1'b0;
    end else if (load_done) begin
      out_valid   <= 1'b1;
      out_result  <= mul_result;
      out_tag     <= tag;
      out_nar     <= mul_nar;
      out_zero    <= mul_zero;
      out_timeout <= 1'b0;
    end else if (load_timeout) begin
      out_valid   <= 1'b1;
      out_result  <= 32'h8000_0000;
      out_tag     <= tag;
      out_nar     <= 1'b1;
      out_zero    <= 1'b0;
      out_timeout <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_posit_mul_sequencer.sv
// Directed bench for posit_mul_sequencer: a behavioural posit_mul model plus a
// scoreboard monitor; a second instance with a short watchdog covers the abort path.
module tb_posit_mul_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  tag;
    logic        nar;
    logic        zero;
    logic        timeout;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        nar;
    logic        zero;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid, in_ready, mul_start, mul_done, mul_nar, mul_zero;
  logic [31:0] in_a, in_b, mul_a, mul_b, mul_result, out_result;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready, out_nar, out_zero, out_timeout, busy;
  logic [2:0]  fifo_count;

  logic        t_in_valid, t_in_ready, t_mul_start, t_mul_done;
  logic [31:0] t_in_a, t_in_b, t_mul_a, t_mul_b, t_out_result;
  logic [3:0]  t_in_tag, t_out_tag;
  logic        t_out_valid, t_out_ready, t_out_nar, t_out_zero, t_out_timeout, t_busy;
  logic [2:0]  t_fifo_count;

  posit_mul_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .mul_result(mul_result), .mul_nar(mul_nar), .mul_zero(mul_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_nar(out_nar), .out_zero(out_zero), .out_timeout(out_timeout),
    .busy(busy), .fifo_count(fifo_count)
  );

  posit_mul_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(8)) t_dut (
    .clk(clk), .rst(rst),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_a(t_in_a), .in_b(t_in_b), .in_tag(t_in_tag),
    .mul_start(t_mul_start), .mul_a(t_mul_a), .mul_b(t_mul_b), .mul_done(t_mul_done),
    .mul_result(32'h1234_5678), .mul_nar(1'b0), .mul_zero(1'b1),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_result(t_out_result), .out_tag(t_out_tag),
    .out_nar(t_out_nar), .out_zero(t_out_zero), .out_timeout(t_out_timeout),
    .busy(t_busy), .fifo_count(t_fifo_count)
  );

  exp_t exp_q[$];
  op_t  op_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_results = 0;
  int   n_starts = 0;
  int   push_cyc = 0;
  int   start_cyc = 0;
  int   fall_cyc = 0;
  int   fall_epoch = -1;
  int   epoch = 0;
  int   mdl_delay = 4;
  int   mdl_hold = 1;
  logic mdl_busy = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expired(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=bound expired required=event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                               input logic [31:0] r, input logic nar, input logic zero);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    if (!in_ready) begin
      expired("push_ready");
      in_valid = 1'b0;
      return;
    end
    push_cyc = cyc;
    op_q.push_back('{a, b, r, nar, zero});
    exp_q.push_back('{r, tag, nar, zero, 1'b0});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy || mdl_busy) && g < budget) begin
      tick();
      g++;
    end
    if (g >= budget) expired(name);
  endtask

  task automatic waitOutValid(input string name, input int budget);
    int g;
    g = 0;
    while (!out_valid && g < budget) begin
      tick();
      g++;
    end
    if (!out_valid) expired(name);
  endtask

  // Behavioural posit_mul: answers each start with the response queued by the stimulus.
  initial begin : mul_model
    op_t op;
    int  my_epoch;
    mul_done = 1'b0;
    mul_result = '0;
    mul_nar = 1'b0;
    mul_zero = 1'b0;
    forever begin
      tick();
      if (mul_start && !rst) begin
        my_epoch = epoch;
        mdl_busy = 1'b1;
        start_cyc = cyc;
        n_starts++;
        if (fall_epoch == epoch) checkOutput("issue_after_done_fall", (cyc - fall_cyc) >= 2, 1);
        if (op_q.size() == 0) begin
          expired("unexpected_start");
          op = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        end else begin
          op = op_q.pop_front();
          checkOutput("mul_a", mul_a, op.a);
          checkOutput("mul_b", mul_b, op.b);
        end
        tick();
        checkOutput("start_single_pulse", mul_start, 0);
        repeat (mdl_delay - 1) tick();
        if (epoch == my_epoch) checkOutput("mul_a_held", mul_a, op.a);
        mul_done = 1'b1;
        mul_result = op.result;
        mul_nar = op.nar;
        mul_zero = op.zero;
        repeat (mdl_hold) tick();
        mul_done = 1'b0;
        fall_cyc = cyc;
        fall_epoch = my_epoch;
        mdl_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: pops on every accepted result and checks hold stability.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_result;
  logic [3:0]  prev_tag;
  logic [2:0]  prev_flags;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_result", out_result, prev_result);
        checkOutput("hold_tag", out_tag, prev_tag);
        checkOutput("hold_flags", {out_nar, out_zero, out_timeout}, prev_flags);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: actual tag=%h result=%h required=no result", out_tag, out_result);
        end else begin
          e = exp_q.pop_front();
          n_results++;
          checkOutput("out_result", out_result, e.result);
          checkOutput("out_tag", out_tag, e.tag);
          checkOutput("out_nar", out_nar, e.nar);
          checkOutput("out_zero", out_zero, e.zero);
          checkOutput("out_timeout", out_timeout, e.timeout);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_result = out_result;
      prev_tag = out_tag;
      prev_flags = {out_nar, out_zero, out_timeout};
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_time_limit: actual=expired required=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

  initial begin : stimulus
    int g;
    int snap;
    int seen;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    t_in_valid = 1'b0; t_in_a = '0; t_in_b = '0; t_in_tag = '0; t_out_ready = 1'b0; t_mul_done = 1'b0;
    repeat (3) tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mul_start", mul_start, 0);
    checkOutput("rst_mul_a", mul_a, 0);
    rst = 1'b0;
    tick();

    // 1.0 x 0x48000000 with done 10 cycles after start
    mdl_delay = 10; mdl_hold = 1; out_ready = 1'b1;
    applyStimulus(32'h4000_0000, 32'h4800_0000, 4'd3, 32'h4800_0000, 1'b0, 1'b0);
    waitOutValid("t1_out_valid", 40);
    checkOutput("t1_start_latency", start_cyc - push_cyc, 2);
    checkOutput("t1_result_latency", cyc - start_cyc, 11);
    waitDrain("t1_drain", 100);

    // Fill the FIFO while the result slot is blocked
    out_ready = 1'b0; mdl_delay = 3;
    applyStimulus(32'h5000_0000, 32'h5000_0000, 4'd15, 32'h6000_0000, 1'b0, 1'b0);
    waitOutValid("t2_slot_fill", 40);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(32'h4100_0000 + i, 32'h3f00_0000 - i, 4'(i), 32'h4200_0000 + i, 1'b0, 1'b0);
    checkOutput("t2_in_ready_full", in_ready, 0);
    checkOutput("t2_count_full", fifo_count, DEPTH);
    in_valid = 1'b1; in_a = 32'h7777_7777; in_b = 32'h7777_7777; in_tag = 4'd4;
    repeat (2) tick();
    in_valid = 1'b0;
    checkOutput("t2_extra_refused", fifo_count, DEPTH);
    out_ready = 1'b1;
    waitDrain("t2_drain", 300);

    // Back-pressure: second op held until the first result is taken
    out_ready = 1'b0; mdl_delay = 3;
    applyStimulus(32'h4800_0000, 32'h4800_0000, 4'd5, 32'h5000_0000, 1'b0, 1'b0);
    applyStimulus(32'h0000_0000, 32'h4800_0000, 4'd6, 32'h0000_0000, 1'b0, 1'b1);
    waitOutValid("t3_first", 40);
    snap = n_starts;
    repeat (8) tick();
    checkOutput("t3_no_issue_starts", n_starts, snap);
    checkOutput("t3_no_issue_count", fifo_count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (2) tick();
    checkOutput("t3_issued_count", fifo_count, 0);
    checkOutput("t3_issued_starts", n_starts, snap + 1);
    repeat (6) tick();
    out_ready = 1'b1;
    waitDrain("t3_drain", 100);

    // Level done held for 5 cycles must yield exactly one result per op
    mdl_delay = 2; mdl_hold = 5; out_ready = 1'b1;
    snap = n_results;
    applyStimulus(32'h8000_0000, 32'h4000_0000, 4'd7, 32'h8000_0000, 1'b1, 1'b0);
    applyStimulus(32'h4c00_0000, 32'h4000_0000, 4'd8, 32'h4c00_0000, 1'b0, 1'b0);
    waitDrain("t5_drain", 100);
    repeat (4) tick();
    checkOutput("t5_result_count", n_results - snap, 2);
    mdl_hold = 1;

    // Watchdog abort on the TIMEOUT=8 instance
    t_in_valid = 1'b1; t_in_a = 32'h4400_0000; t_in_b = 32'h4600_0000; t_in_tag = 4'd9;
    tick();
    t_in_valid = 1'b0;
    g = 0;
    while (!t_mul_start && g < 10) begin tick(); g++; end
    if (!t_mul_start) expired("t4_start");
    repeat (8) tick();
    checkOutput("t4_not_before_8th", t_out_valid, 0);
    tick();
    checkOutput("t4_valid", t_out_valid, 1);
    checkOutput("t4_result", t_out_result, 32'h8000_0000);
    checkOutput("t4_nar", t_out_nar, 1);
    checkOutput("t4_zero", t_out_zero, 0);
    checkOutput("t4_timeout", t_out_timeout, 1);
    checkOutput("t4_tag", t_out_tag, 9);
    t_mul_done = 1'b1; t_out_ready = 1'b1;
    tick();
    repeat (5) tick();
    checkOutput("t4_drain_busy", t_busy, 1);
    checkOutput("t4_no_reload", t_out_valid, 0);
    checkOutput("t4_mul_a_held", t_mul_a, 32'h4400_0000);
    t_mul_done = 1'b0;
    repeat (2) tick();
    checkOutput("t4_idle", t_busy, 0);

    // Async reset while a multiply is in flight with 3 requests queued
    mdl_delay = 30; out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(32'h4a00_0000 + i, 32'h4000_0000, 4'(10 + i), 32'h4a00_0000 + i, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("t6_queued", fifo_count, 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_count", fifo_count, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_mul_a", mul_a, 0);
    checkOutput("t6_rst_mul_b", mul_b, 0);
    checkOutput("t6_rst_out", {out_valid, out_nar, out_zero, out_timeout, out_tag, out_result}, 0);
    epoch++;
    exp_q.delete();
    op_q.delete();
    tick();
    rst = 1'b0;
    seen = 0;
    g = 0;
    while ((mdl_busy || g < 4) && g < 80) begin
      tick();
      g++;
      if (out_valid || mul_start) seen++;
    end
    checkOutput("t6_late_done_ignored", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
